// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared definitions for the fetch pipeline: FSM encoding and fetch constants.
package fetch_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  // Bubble instruction written into IF/ID on a redirect.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sequential fetch step; PC arithmetic wraps modulo 2^32.
  localparam logic [31:0] PC_INC = 32'd4;

  // Word-align a redirect address by dropping its byte offset.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pipe_ctrl_sat_counter16.sv
// 16-bit performance counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Inc,
  input  logic        Clr,
  output logic [15:0] Count
);

  // Reset and clear win over increment; hold once the all-ones value is reached.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Count <= 16'h0000;
    end else if (Clr) begin
      Count <= 16'h0000;
    end else if (Inc && (Count != 16'hFFFF)) begin
      Count <= Count + 16'h0001;
    end
  end

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch stage control: PC register, IF/ID register, ID/EX valid bit,
// run/stall/redirect FSM, stall watchdog and performance counters.
// Control inputs are sampled only at the rising edge; there is no valid/ready
// handshake -- the hazard unit's write enables and Flush act as level controls
// for the cycle that ends at the next rising edge. Update priority is
// Reset > BranchTaken > stall (write enable low) > normal fetch.
module fetch_pipe_ctrl
  import fetch_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         PCWriteEnable,
  input  logic         IFIDWriteEnable,
  input  logic         Flush,
  input  logic         BranchTaken,
  input  logic [31:0]  BranchTarget,
  input  logic [31:0]  IMemInstruction,
  output logic [31:0]  PC,
  output logic [31:0]  IFIDInstruction,
  output logic [31:0]  IFIDPCPlus4,
  output logic         IFIDValid,
  output logic         IDEXValid,
  output logic [15:0]  StallCycles,
  output logic [15:0]  FlushCount,
  output logic         StallTimeout,
  output logic         MisalignErr,
  output fetch_state_e State
);

  logic [31:0]  pc_plus4;
  fetch_state_e state_next;
  logic [3:0]   stall_cnt;
  logic [3:0]   stall_cnt_next;
  logic         stall_inc;

  assign pc_plus4  = PC + PC_INC;
  assign stall_inc = !PCWriteEnable && !BranchTaken;

  // Next FSM state and consecutive-stall count; the count saturates at 15.
  always_comb begin
    state_next     = ST_RUN;
    stall_cnt_next = 4'd0;
    if (BranchTaken) begin
      state_next = ST_REDIRECT;
    end else if (!PCWriteEnable) begin
      state_next     = ST_STALL;
      stall_cnt_next = (stall_cnt == 4'hF) ? stall_cnt : stall_cnt + 4'd1;
    end
  end

  // FSM with registered state, stall counter and sticky error flags.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      State        <= ST_RUN;
      stall_cnt    <= 4'd0;
      StallTimeout <= 1'b0;
      MisalignErr  <= 1'b0;
    end else begin
      State     <= state_next;
      stall_cnt <= stall_cnt_next;
      if ((state_next == ST_STALL) && ({28'd0, stall_cnt_next} == STALL_LIMIT)) begin
        StallTimeout <= 1'b1;
      end
      if (BranchTaken && (BranchTarget[1:0] != 2'b00)) begin
        MisalignErr <= 1'b1;
      end
    end
  end

  // PC register: a redirect overrides the hazard unit's hold request.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      PC <= RESET_PC;
    end else if (BranchTaken) begin
      PC <= align_target(BranchTarget);
    end else if (PCWriteEnable) begin
      PC <= pc_plus4;
    end
  end

  // IF/ID register: squashed on redirect, held while its write enable is low.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      IFIDInstruction <= NOP_INSTR;
      IFIDPCPlus4     <= 32'h0;
      IFIDValid       <= 1'b0;
    end else if (BranchTaken) begin
      IFIDInstruction <= NOP_INSTR;
      IFIDValid       <= 1'b0;
    end else if (IFIDWriteEnable) begin
      IFIDInstruction <= IMemInstruction;
      IFIDPCPlus4     <= pc_plus4;
      IFIDValid       <= 1'b1;
    end
  end

  // ID/EX valid bit: Flush or an IF/ID bubble produces a bubble downstream.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      IDEXValid <= 1'b0;
    end else begin
      IDEXValid <= IFIDValid && !Flush;
    end
  end

  sat_counter16 u_stall_cycles (
    .Clock (Clock),
    .Reset (Reset),
    .Inc   (stall_inc),
    .Clr   (1'b0),
    .Count (StallCycles)
  );

  sat_counter16 u_flush_count (
    .Clock (Clock),
    .Reset (Reset),
    .Inc   (BranchTaken),
    .Clr   (1'b0),
    .Count (FlushCount)
  );

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl with hand-computed expected values.
module tb_fetch_pipe_ctrl;
  import fetch_pipe_ctrl_pkg::*;

  logic         Clock;
  logic         Reset;
  logic         PCWriteEnable;
  logic         IFIDWriteEnable;
  logic         Flush;
  logic         BranchTaken;
  logic [31:0]  BranchTarget;
  logic [31:0]  IMemInstruction;
  logic [31:0]  PC;
  logic [31:0]  IFIDInstruction;
  logic [31:0]  IFIDPCPlus4;
  logic         IFIDValid;
  logic         IDEXValid;
  logic [15:0]  StallCycles;
  logic [15:0]  FlushCount;
  logic         StallTimeout;
  logic         MisalignErr;
  fetch_state_e State;

  int checks;
  int errors;

  fetch_pipe_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .STALL_LIMIT (15)
  ) u_dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .PCWriteEnable   (PCWriteEnable),
    .IFIDWriteEnable (IFIDWriteEnable),
    .Flush           (Flush),
    .BranchTaken     (BranchTaken),
    .BranchTarget    (BranchTarget),
    .IMemInstruction (IMemInstruction),
    .PC              (PC),
    .IFIDInstruction (IFIDInstruction),
    .IFIDPCPlus4     (IFIDPCPlus4),
    .IFIDValid       (IFIDValid),
    .IDEXValid       (IDEXValid),
    .StallCycles     (StallCycles),
    .FlushCount      (FlushCount),
    .StallTimeout    (StallTimeout),
    .MisalignErr     (MisalignErr),
    .State           (State)
  );

  // Clock and reset block
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges; outputs are then sampled 1 ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic drive(input logic pcwe, input logic ifidwe, input logic flush,
                       input logic bt, input logic [31:0] target, input logic [31:0] instr);
    PCWriteEnable   = pcwe;
    IFIDWriteEnable = ifidwe;
    Flush           = flush;
    BranchTaken     = bt;
    BranchTarget    = target;
    IMemInstruction = instr;
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b0;
    tick(n);
    Reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2008_0005);

    // Reset state
    do_reset(2);
    check("rst_pc", PC, 32'h0);
    check("rst_ifid_instr", IFIDInstruction, 32'h0);
    check("rst_ifid_valid", 32'(IFIDValid), 32'd0);
    check("rst_idex_valid", 32'(IDEXValid), 32'd0);
    check("rst_stall_cycles", 32'(StallCycles), 32'd0);
    check("rst_flags", {30'd0, StallTimeout, MisalignErr}, 32'd0);
    check("rst_state", 32'(State), 32'(ST_RUN));

    // First fetch at RESET_PC
    tick(1);
    check("fetch1_pc", PC, 32'h4);
    check("fetch1_instr", IFIDInstruction, 32'h2008_0005);
    check("fetch1_pcp4", IFIDPCPlus4, 32'h4);
    check("fetch1_valid", 32'(IFIDValid), 32'd1);
    tick(1);
    check("fetch2_idex_valid", 32'(IDEXValid), 32'd1);
    IMemInstruction = 32'h1111_1111;
    tick(2);
    check("run_pc_0x10", PC, 32'h10);

    // Full stall with flush for 3 cycles at PC 0x10
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    tick(3);
    check("stall_pc_hold", PC, 32'h10);
    check("stall_ifid_instr_hold", IFIDInstruction, 32'h1111_1111);
    check("stall_ifid_pcp4_hold", IFIDPCPlus4, 32'h10);
    check("stall_ifid_valid_hold", 32'(IFIDValid), 32'd1);
    check("stall_idex_bubble", 32'(IDEXValid), 32'd0);
    check("stall_cycles_3", 32'(StallCycles), 32'd3);
    check("stall_state", 32'(State), 32'(ST_STALL));

    // Branch overrides both hold requests
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    tick(1);
    check("br_pc", PC, 32'h40);
    check("br_ifid_valid", 32'(IFIDValid), 32'd0);
    check("br_ifid_instr_nop", IFIDInstruction, 32'h0);
    check("br_flush_count", 32'(FlushCount), 32'd1);
    check("br_stall_cycles_unchanged", 32'(StallCycles), 32'd3);
    check("br_state_redirect", 32'(State), 32'(ST_REDIRECT));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2222_2222);
    tick(1);
    check("br_state_run", 32'(State), 32'(ST_RUN));
    check("br_next_pc", PC, 32'h44);
    check("br_idex_bubble", 32'(IDEXValid), 32'd0);
    check("br_refill_valid", 32'(IFIDValid), 32'd1);
    check("br_misalign_clear", 32'(MisalignErr), 32'd0);

    // Misaligned redirect is aligned and flagged
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h43, 32'h2222_2222);
    tick(1);
    check("mis_pc", PC, 32'h40);
    check("mis_flag", 32'(MisalignErr), 32'd1);
    check("mis_flush_count", 32'(FlushCount), 32'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2222_2222);
    tick(10);
    check("mis_flag_sticky", 32'(MisalignErr), 32'd1);
    check("mis_pc_after10", PC, 32'h68);

    // Stall watchdog
    do_reset(1);
    check("wd_rst_misalign", 32'(MisalignErr), 32'd0);
    check("wd_rst_flush_count", 32'(FlushCount), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3333_3333);
    tick(14);
    check("wd_14_no_timeout", 32'(StallTimeout), 32'd0);
    tick(1);
    check("wd_15_timeout", 32'(StallTimeout), 32'd1);
    tick(1);
    check("wd_16_sticky", 32'(StallTimeout), 32'd1);
    check("wd_stall_cycles", 32'(StallCycles), 32'd16);
    check("wd_pc_hold", PC, 32'h0);
    do_reset(1);
    check("wd_rst_clear", 32'(StallTimeout), 32'd0);
    check("wd_rst_state", 32'(State), 32'(ST_RUN));
    check("wd_rst_stall_cycles", 32'(StallCycles), 32'd0);

    // Consecutive-stall count restarts after leaving STALL
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3333_3333);
    tick(10);
    PCWriteEnable = 1'b1;
    tick(1);
    PCWriteEnable = 1'b0;
    tick(10);
    check("wd_split_no_timeout", 32'(StallTimeout), 32'd0);

    // Reset mid-stall leaves nothing behind
    do_reset(1);
    check("mid_rst_state", 32'(State), 32'(ST_RUN));
    check("mid_rst_pc", PC, 32'h0);
    check("mid_rst_ifid_valid", 32'(IFIDValid), 32'd0);

    // Saturation of StallCycles
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(65534);
    check("sat_fffe", 32'(StallCycles), 32'h0000_FFFE);
    tick(3);
    check("sat_ffff", 32'(StallCycles), 32'h0000_FFFF);

    // PC wrap
    do_reset(1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    tick(1);
    check("wrap_pc_top", PC, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4444_4444);
    tick(1);
    check("wrap_pc_zero", PC, 32'h0);
    check("wrap_pcp4_zero", IFIDPCPlus4, 32'h0);
    check("wrap_no_flags", {30'd0, StallTimeout, MisalignErr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pipe_ctrl.md
FETCH_PIPE_CTRL -- requirements
Module: fetch_pipe_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter STALL_LIMIT, default 15, meaning the consecutive-stall count that raises StallTimeout.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 Clock  in  1  the single rising-edge clock.
REQ-005 Reset  in  1  synchronous active-low reset.
REQ-006 PCWriteEnable  in  1  hazard unit: 0 holds the PC.
REQ-007 IFIDWriteEnable  in  1  hazard unit: 0 holds the IF/ID register.
REQ-008 Flush  in  1  hazard unit: insert a bubble into ID/EX.
REQ-009 BranchTaken  in  1  redirect the fetch stream this cycle.
REQ-010 BranchTarget  in  32  redirect address.
REQ-011 IMemInstruction  in  32  instruction read combinationally at PC.
REQ-012 PC  out  32  current fetch address.
REQ-013 IFIDInstruction / IFIDPCPlus4  out  32 each  IF/ID register contents.
REQ-014 IFIDValid / IDEXValid  out  1 each  stage-valid bits; 0 marks a bubble.
REQ-015 StallCycles / FlushCount  out  16 each  saturating performance counters.
REQ-016 StallTimeout / MisalignErr  out  1 each  sticky error flags.

Function
REQ-017 SHALL sample all inputs on the rising edge only (the hazard unit drives them from the falling edge), so every control input takes effect at the next rising edge.
REQ-018 SHALL apply update priority Reset > BranchTaken > stall > normal.
REQ-019 Normal case (BranchTaken=0, PCWriteEnable=1, IFIDWriteEnable=1): PC<=PC+4 (mod 2^32); IFIDInstruction<=IMemInstruction; IFIDPCPlus4<=PC+4; IFIDValid<=1.
REQ-020 BranchTaken=1: PC<={BranchTarget[31:2],2'b00}; IFIDInstruction<=32'h0; IFIDValid<=0; FlushCount increments; these take effect regardless of PCWriteEnable and IFIDWriteEnable.
REQ-021 BranchTarget[1:0]!=0 while BranchTaken=1 SHALL set MisalignErr, which holds until reset.
REQ-022 PCWriteEnable=0 SHALL hold the PC; IFIDWriteEnable=0 SHALL hold all IF/ID fields; the two enables act independently.
REQ-023 IDEXValid SHALL be registered as 0 when Flush=1 or IFIDValid=0, and as IFIDValid otherwise; Flush never alters the IF/ID register.
REQ-024 FSM states: RUN, STALL, REDIRECT.
REQ-025 FSM transitions from any state: BranchTaken -> REDIRECT; else PCWriteEnable=0 -> STALL; else -> RUN.
REQ-026 REDIRECT SHALL last exactly one cycle unless BranchTaken is reasserted.
REQ-027 In STALL, a 4-bit consecutive-stall counter SHALL increment each cycle.
REQ-028 StallTimeout SHALL set (sticky) when the consecutive-stall counter reaches STALL_LIMIT.
REQ-029 The consecutive-stall counter SHALL clear on leaving STALL.
REQ-030 StallCycles SHALL increment on every cycle with PCWriteEnable=0 and BranchTaken=0, saturating at 16'hFFFF.
REQ-031 FlushCount SHALL saturate at 16'hFFFF.
REQ-032 A PC wrap from 32'hFFFF_FFFC SHALL produce 32'h0000_0000 with no flag raised.

Reset
REQ-033 Reset=0 at a rising edge SHALL set: PC=RESET_PC; IFID fields=0; IFIDValid=0; IDEXValid=0; counters=0; flags=0; state=RUN.
REQ-034 Reset SHALL take priority over every other input, including mid-stall or mid-redirect, and no partial update SHALL survive it.
REQ-035 The first fetch after reset deassertion SHALL occur at RESET_PC.

Structure
REQ-036 A shared pipeline package SHALL hold the FSM state encoding, the NOP constant (32'h0), and the PC increment constant (4).
REQ-037 The two 16-bit saturating counters SHALL be instances of one sub-module, sat_counter16, with ports Clock, Reset, Inc, Clr, Count.

Verification
REQ-038 Reset low for 2 cycles, then high with IMemInstruction=32'h2008_0005 -> PC=0 then 4; IFIDInstruction=32'h2008_0005; IFIDValid=1.
REQ-039 PCWriteEnable=0, IFIDWriteEnable=0, Flush=1 for 3 cycles at PC=0x10 -> PC holds 0x10; IF/ID holds; IDEXValid=0; StallCycles=3; state STALL.
REQ-040 BranchTaken=1, BranchTarget=0x40, concurrent with PCWriteEnable=0 -> PC=0x40; IFIDValid=0; FlushCount=1; state REDIRECT then RUN.
REQ-041 BranchTarget=0x43 taken -> PC=0x40; MisalignErr=1 and still 1 after 10 more cycles.
REQ-042 PCWriteEnable=0 for 16 cycles -> StallTimeout=1 at the 15th stall cycle; Reset clears it.
REQ-043 Force StallCycles=16'hFFFE, then stall 3 cycles -> StallCycles=16'hFFFF; PC=0xFFFF_FFFC normal fetch -> PC=0.
